// File: rtl/vu_vmu_load_wb_pkg.sv
// Shared definitions for the VMU load writeback path.
// Combinational helpers only; no latency.
// No flow control in this file.
package vu_vmu_load_wb_pkg;

    // Width of one reorder-queue data entry; the ROQ uses the same constant.
    localparam int ROQ_DATA_SIZE = 128;
    // Width of one writeback element after sign/zero extension.
    localparam int ELEM_EXT_SIZE = 64;

    // Element width encodings carried on cmd_bits_typ.
    typedef enum logic [1:0] {
        TYP_B = 2'd0,   // 8-bit
        TYP_H = 2'd1,   // 16-bit
        TYP_W = 2'd2,   // 32-bit
        TYP_D = 2'd3    // 64-bit
    } typ_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Slots per entry: how many elements of the given width fit in one entry.
    function automatic logic [4:0] spe(input logic [1:0] typ);
        logic [4:0] n;
        case (typ)
            TYP_B:   n = 5'd16;
            TYP_H:   n = 5'd8;
            TYP_W:   n = 5'd4;
            default: n = 5'd2;
        endcase
        return n;
    endfunction

    // Index of the final slot in an entry (SPE-1); slot counter is 4 bits.
    function automatic logic [3:0] slot_last(input logic [1:0] typ);
        logic [4:0] n;
        n = spe(typ) - 5'd1;
        return n[3:0];
    endfunction

endpackage

// File: rtl/vu_vmu_elem_extract.sv
// Selects one element of a ROQ entry by slot and width, then sign/zero-extends it to 64 bits.
// Purely combinational, zero latency.
// No flow control; the caller owns all handshakes.
//
// Ports:
//   entry  - 128-bit ROQ entry, slot 0 in the LSBs
//   slot   - element slot within the entry (range depends on typ)
//   typ    - element width code (8/16/32/64 bits)
//   sgn    - 1 = sign-extend, 0 = zero-extend (ignored for 64-bit)
//   elem   - extended 64-bit element
module vu_vmu_elem_extract
    import vu_vmu_load_wb_pkg::*;
(
    input  logic [ROQ_DATA_SIZE-1:0] entry,
    input  logic [3:0]               slot,
    input  logic [1:0]               typ,
    input  logic                     sgn,
    output logic [ELEM_EXT_SIZE-1:0] elem
);

    // Each width only uses as many slot bits as it has slots, so the bit
    // offsets below can never run past the top of the entry.
    logic [7:0]  elem_b;
    logic [15:0] elem_h;
    logic [31:0] elem_w;
    logic [63:0] elem_d;

    assign elem_b = entry[{slot, 3'b000} +: 8];
    assign elem_h = entry[{slot[2:0], 4'b0000} +: 16];
    assign elem_w = entry[{slot[1:0], 5'b00000} +: 32];
    assign elem_d = entry[{slot[0], 6'b000000} +: 64];

    always_comb begin
        elem = '0;
        case (typ)
            TYP_B:   elem = {{56{sgn & elem_b[7]}}, elem_b};
            TYP_H:   elem = {{48{sgn & elem_h[15]}}, elem_h};
            TYP_W:   elem = {{32{sgn & elem_w[31]}}, elem_w};
            default: elem = elem_d;
        endcase
    end

endmodule

// File: rtl/vu_vmu_load_wb.sv
// Unpacks in-order 128-bit ROQ load entries into extended elements for VRF writeback.
// Zero latency: wb outputs are combinational from the ROQ head plus registered slot/index.
// Stalls hold all outputs when wb_rdy=0; wb_val drops when the ROQ head is not valid.
//
// Ports:
//   clk, reset                     - clock, synchronous active-high reset
//   cmd_bits_vlen/typ/signed       - command: element count-1, element width, extension mode
//   cmd_val / cmd_rdy              - command handshake (accepted only when idle)
//   roq_deq_data_bits/val/rdy      - ROQ head entry; rdy pops the head this cycle
//   wb_data_bits/elem_idx/last     - writeback element, destination index, final-element flag
//   wb_val / wb_rdy                - writeback handshake
//   busy                           - a command is in progress
module vu_vmu_load_wb #(
    parameter int ROQ_DATA_SIZE = 128,
    parameter int VLEN_SIZE     = 11,
    parameter int WB_DATA_SIZE  = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [VLEN_SIZE-1:0]     cmd_bits_vlen,
    input  logic [1:0]               cmd_bits_typ,
    input  logic                     cmd_bits_signed,
    input  logic                     cmd_val,
    output logic                     cmd_rdy,
    input  logic [ROQ_DATA_SIZE-1:0] roq_deq_data_bits,
    input  logic                     roq_deq_data_val,
    output logic                     roq_deq_data_rdy,
    output logic [WB_DATA_SIZE-1:0]  wb_data_bits,
    output logic [VLEN_SIZE-1:0]     wb_elem_idx,
    output logic                     wb_last,
    output logic                     wb_val,
    input  logic                     wb_rdy,
    output logic                     busy
);

    import vu_vmu_load_wb_pkg::*;

    state_t               state;
    logic [VLEN_SIZE-1:0] elem_idx;
    logic [VLEN_SIZE-1:0] vlen_q;
    logic [3:0]           slot;
    logic [1:0]           typ_q;
    logic                 signed_q;

    logic                 run;
    logic                 fire;
    logic                 slot_end;

    // Reset is synchronous, so the state register may still read RUN during the
    // reset cycle; every handshake is gated so nothing fires or pops then.
    assign run      = (state == RUN) && !reset;
    assign cmd_rdy  = (state == IDLE) && !reset;
    assign busy     = run;

    assign wb_val   = run && roq_deq_data_val;
    assign fire     = wb_val && wb_rdy;
    assign wb_last  = (elem_idx == vlen_q);
    assign slot_end = (slot == slot_last(typ_q));

    assign wb_elem_idx = elem_idx;

    // Pop when the entry's last slot is consumed, or when the command ends
    // part-way through an entry (entries are never shared across commands).
    assign roq_deq_data_rdy = fire && (slot_end || wb_last);

    vu_vmu_elem_extract u_extract (
        .entry (roq_deq_data_bits),
        .slot  (slot),
        .typ   (typ_q),
        .sgn   (signed_q),
        .elem  (wb_data_bits)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            elem_idx <= '0;
            vlen_q   <= '0;
            slot     <= '0;
            typ_q    <= TYP_B;
            signed_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_val) begin
                        vlen_q   <= cmd_bits_vlen;
                        typ_q    <= cmd_bits_typ;
                        signed_q <= cmd_bits_signed;
                        elem_idx <= '0;
                        slot     <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (fire) begin
                        if (wb_last) begin
                            // Index stays at vlen so it never wraps within a command.
                            slot  <= '0;
                            state <= IDLE;
                        end else begin
                            elem_idx <= elem_idx + 1'b1;
                            slot     <= slot_end ? 4'd0 : slot + 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vu_vmu_load_wb.sv
// Directed bench for vu_vmu_load_wb with an expected-element scoreboard.
// Inputs are driven #1 after the rising edge; outputs are sampled on the falling edge.
// Covers reset, all element widths, partial entries, writeback stalls, ROQ gaps and mid-command reset.
module tb_vu_vmu_load_wb;

    logic         clk = 1'b0;
    logic         reset;
    logic [10:0]  cmd_bits_vlen;
    logic [1:0]   cmd_bits_typ;
    logic         cmd_bits_signed;
    logic         cmd_val;
    logic         cmd_rdy;
    logic [127:0] roq_deq_data_bits;
    logic         roq_deq_data_val;
    logic         roq_deq_data_rdy;
    logic [63:0]  wb_data_bits;
    logic [10:0]  wb_elem_idx;
    logic         wb_last;
    logic         wb_val;
    logic         wb_rdy;
    logic         busy;

    always #5 clk = ~clk;

    vu_vmu_load_wb dut (
        .clk               (clk),
        .reset             (reset),
        .cmd_bits_vlen     (cmd_bits_vlen),
        .cmd_bits_typ      (cmd_bits_typ),
        .cmd_bits_signed   (cmd_bits_signed),
        .cmd_val           (cmd_val),
        .cmd_rdy           (cmd_rdy),
        .roq_deq_data_bits (roq_deq_data_bits),
        .roq_deq_data_val  (roq_deq_data_val),
        .roq_deq_data_rdy  (roq_deq_data_rdy),
        .wb_data_bits      (wb_data_bits),
        .wb_elem_idx       (wb_elem_idx),
        .wb_last           (wb_last),
        .wb_val            (wb_val),
        .wb_rdy            (wb_rdy),
        .busy              (busy)
    );

    typedef struct {
        logic [63:0] data;
        logic [10:0] idx;
        logic        last;
        logic        pop;
    } exp_t;

    exp_t         sb[$];
    logic [127:0] ents[$];
    int           n_cmp = 0;
    int           n_mis = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference element: shift the entry down, mask to width, then extend.
    function automatic logic [63:0] model(input logic [127:0] e, input int typ, input bit sgn, input int slot);
        int           w;
        logic [127:0] sh;
        logic [63:0]  m;
        logic [63:0]  v;
        w  = 8 << typ;
        sh = e >> (slot * w);
        m  = (typ == 3) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        v  = sh[63:0] & m;
        if (sgn && typ != 3 && v[w-1]) v = v | ~m;
        return v;
    endfunction

    task automatic push_exp(input logic [63:0] d, input int idx, input bit last, input bit pop);
        exp_t e;
        e.data = d;
        e.idx  = 11'(idx);
        e.last = last;
        e.pop  = pop;
        sb.push_back(e);
    endtask

    task automatic push_model(input int vlen, input int typ, input bit sgn);
        int n;
        n = 16 >> typ;
        for (int i = 0; i <= vlen; i++)
            push_exp(model(ents[i / n], typ, sgn, i % n), i,
                     i == vlen, ((i % n) == n - 1) || (i == vlen));
    endtask

    task automatic rand_ents(input int k);
        ents.delete();
        for (int i = 0; i < k; i++)
            ents.push_back({$urandom, $urandom, $urandom, $urandom});
    endtask

    // Issue one command and stream the queued entries through it.
    // stall_at/gap_at/abort_at name the fired-element count at which to apply
    // 3 cycles of wb_rdy=0, 2 cycles of roq val=0, or a reset (-1 = never).
    task automatic run(input int vlen, input int typ, input bit sgn,
                       input int stall_at, input int gap_at, input int abort_at, input bit junk);
        int   fired, ei, st, gp, cyc;
        bit   done, in_stall, in_gap, do_abort;
        exp_t e;
        cmd_bits_vlen   = 11'(vlen);
        cmd_bits_typ    = 2'(typ);
        cmd_bits_signed = sgn;
        cmd_val         = 1'b1;
        roq_deq_data_val = 1'b0;
        wb_rdy          = 1'b1;
        @(negedge clk);
        chk("cmd_rdy_idle", cmd_rdy, 1);
        chk("busy_idle", busy, 0);
        @(posedge clk); #1;
        cmd_val = 1'b0;
        fired = 0; ei = 0; st = 0; gp = 0; cyc = 0; done = 0;
        while (!done && cyc < 300) begin
            cyc++;
            if (junk) begin
                // A competing command during RUN must be ignored.
                cmd_val       = (fired < 2);
                cmd_bits_vlen = 11'd0;
                cmd_bits_typ  = 2'd3;
            end
            in_stall = (fired == stall_at) && (st < 3);
            in_gap   = (fired == gap_at) && (gp < 2);
            do_abort = (fired == abort_at);
            roq_deq_data_val  = !in_gap && (ei < ents.size());
            roq_deq_data_bits = (ei < ents.size()) ? ents[ei] : 128'd0;
            wb_rdy = !in_stall;
            reset  = do_abort;
            @(negedge clk);
            if (do_abort) begin
                chk("rst_cmd_rdy", cmd_rdy, 0);
                chk("rst_busy", busy, 0);
                chk("rst_wb_val", wb_val, 0);
                chk("rst_pop", roq_deq_data_rdy, 0);
            end else begin
                chk("run_busy", busy, 1);
                chk("run_cmd_rdy", cmd_rdy, 0);
                chk("wb_val", wb_val, roq_deq_data_val);
                if (sb.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                    done = 1;
                end else if (in_stall) begin
                    st++;
                    chk("stall_data", wb_data_bits, sb[0].data);
                    chk("stall_idx", wb_elem_idx, 64'(sb[0].idx));
                    chk("stall_pop", roq_deq_data_rdy, 0);
                end else if (in_gap) begin
                    gp++;
                    chk("gap_idx", wb_elem_idx, 64'(sb[0].idx));
                    chk("gap_pop", roq_deq_data_rdy, 0);
                end else if (wb_val) begin
                    e = sb.pop_front();
                    chk("wb_data", wb_data_bits, e.data);
                    chk("wb_idx", wb_elem_idx, 64'(e.idx));
                    chk("wb_last", wb_last, e.last);
                    chk("pop", roq_deq_data_rdy, e.pop);
                    fired++;
                    if (e.pop) ei++;
                    if (e.last) done = 1;
                end
            end
            @(posedge clk); #1;
            if (do_abort) begin
                reset = 1'b0;
                sb.delete();
                done  = 1;
            end
        end
        if (!done) chk("timeout", 1, 0);
        cmd_val = 1'b0;
        roq_deq_data_val = 1'b0;
        wb_rdy = 1'b1;
        @(negedge clk);
        chk("end_cmd_rdy", cmd_rdy, 1);
        chk("end_busy", busy, 0);
        chk("end_wb_val", wb_val, 0);
        chk("end_pop", roq_deq_data_rdy, 0);
        chk("end_sb_empty", 64'(sb.size()), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset with all inputs asserted: outputs must still be quiet.
        reset = 1'b1;
        cmd_bits_vlen = 11'd5; cmd_bits_typ = 2'd0; cmd_bits_signed = 1'b0;
        cmd_val = 1'b1; roq_deq_data_val = 1'b1; wb_rdy = 1'b1;
        roq_deq_data_bits = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
        @(posedge clk); #1;
        @(negedge clk);
        chk("reset_cmd_rdy", cmd_rdy, 0);
        chk("reset_busy", busy, 0);
        chk("reset_wb_val", wb_val, 0);
        chk("reset_pop", roq_deq_data_rdy, 0);
        @(posedge clk); #1;
        reset = 1'b0; cmd_val = 1'b0; roq_deq_data_val = 1'b0;
        @(negedge clk);
        chk("idle_cmd_rdy", cmd_rdy, 1);
        chk("idle_wb_val", wb_val, 0);
        @(posedge clk); #1;

        // Case 1: two 64-bit elements, one pop on the second.
        ents.delete();
        ents.push_back(128'h00000000_00000002_00000000_00000001);
        push_exp(64'h1, 0, 0, 0);
        push_exp(64'h2, 1, 1, 1);
        run(1, 3, 0, -1, -1, -1, 0);

        // Case 2: signed bytes, partial final entry popped on the 5th element.
        ents.delete();
        ents.push_back({88'hAAAA_AAAA_AAAA_AAAA_AAAA_AA, 40'h00_01_FF_7F_80});
        push_exp(64'hFFFF_FFFF_FFFF_FF80, 0, 0, 0);
        push_exp(64'h7F, 1, 0, 0);
        push_exp(64'hFFFF_FFFF_FFFF_FFFF, 2, 0, 0);
        push_exp(64'h1, 3, 0, 0);
        push_exp(64'h0, 4, 1, 1);
        run(4, 0, 1, -1, -1, -1, 0);

        // Case 3: unsigned words over 3 entries, with a competing command ignored.
        rand_ents(3);
        ents[0][31] = 1'b1;
        push_model(9, 2, 0);
        run(9, 2, 0, -1, -1, -1, 1);

        // Case 4: signed halfwords with a 3-cycle writeback stall mid-entry.
        rand_ents(2);
        ents[0][63] = 1'b1;
        push_model(11, 1, 1);
        run(11, 1, 1, 3, -1, -1, 0);

        // Case 5: unsigned bytes with a 2-cycle ROQ gap mid-command.
        rand_ents(2);
        push_model(20, 0, 0);
        run(20, 0, 0, -1, 5, -1, 0);

        // Case 6: reset while presenting element 3, then a fresh command.
        rand_ents(2);
        push_model(7, 2, 1);
        run(7, 2, 1, -1, -1, 3, 0);
        rand_ents(2);
        push_model(2, 3, 0);
        run(2, 3, 0, -1, -1, -1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vu_vmu_load_wb.md
Name: vu_vmu_load_wb

Overview:
- Writeback-side consumer of the VMU reorder queue.
- Takes in-order 128-bit load-response entries from the ROQ dequeue port.
- Unpacks each entry into individual vector elements of the commanded width, and sign- or zero-extends each element to 64 bits.
- Presents one element per cycle to the vector register file writeback port, under a per-instruction command (vector length, element type).

Parameters:
- ROQ_DATA_SIZE, 128, width of one ROQ data entry; must be 128.
- VLEN_SIZE, 11, width of the vector-length field and the element index.
- WB_DATA_SIZE, 64, width of one writeback element after extension.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- cmd_bits_vlen  input  VLEN_SIZE  element count minus one (0 = 1 element).
- cmd_bits_typ  input  2  element width: 0=8b, 1=16b, 2=32b, 3=64b.
- cmd_bits_signed  input  1  1 = sign-extend, 0 = zero-extend.
- cmd_val  input  1  command valid.
- cmd_rdy  output  1  block can accept a command.
- roq_deq_data_bits  input  ROQ_DATA_SIZE  head ROQ entry.
- roq_deq_data_val  input  1  head entry valid.
- roq_deq_data_rdy  output  1  pop head entry this cycle.
- wb_data_bits  output  WB_DATA_SIZE  extended element.
- wb_elem_idx  output  VLEN_SIZE  destination element index.
- wb_last  output  1  this is the final element of the command.
- wb_val  output  1  writeback valid.
- wb_rdy  input  1  writeback accepted.
- busy  output  1  a command is in progress.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, elem_idx=0, slot=0, latched command cleared. While reset is high, cmd_rdy=0, wb_val=0, roq_deq_data_rdy=0, busy=0.
- Reset asserted mid-command: the command is abandoned, no ROQ pop occurs in that cycle, and the block returns to IDLE.
- FSM, two states:
  - IDLE: cmd_rdy=1, busy=0, wb_val=0, roq_deq_data_rdy=0. When cmd_val=1, latch vlen, typ and signed, clear elem_idx and slot, and go to RUN on the next cycle.
  - RUN: cmd_rdy=0, busy=1. Commands presented during RUN are ignored until the block returns to IDLE.
- Slots per entry: SPE = 16/8/4/2 for typ 0/1/2/3.
- Element extraction: the element is roq_deq_data_bits[slot*W +: W], where W = 8<<typ. Slot 0 is the LSBs.
- Extension: sign- or zero-extend the element to 64 bits; typ=3 passes through unchanged.
- Output path (RUN), zero latency:
  - wb_val = roq_deq_data_val.
  - wb_data_bits, wb_elem_idx and wb_last are combinational from the head entry and the registered slot/elem_idx.
  - wb_last = (elem_idx == vlen).
- Writeback fire = wb_val & wb_rdy. On fire:
  - elem_idx increments.
  - slot increments, wrapping to 0 at SPE-1.
- Pop rule: roq_deq_data_rdy = fire & ((slot == SPE-1) | wb_last). There is a combinational path wb_rdy -> roq_deq_data_rdy; the ROQ dequeue handshake tolerates it.
- A partially used final entry is popped with the last element. Entries are never shared between commands; every command starts at slot 0 of a fresh entry.
- Fire with wb_last: transition to IDLE and clear slot. cmd_rdy rises in the next cycle. Back-to-back commands therefore have one idle cycle between them.
- Stalls:
  - roq_deq_data_val=0: wb_val=0 and no state change.
  - wb_rdy=0 with wb_val=1: all outputs hold stable, no pop.
- elem_idx never exceeds vlen; no wraparound within a command. vlen is at most 2^VLEN_SIZE-1.

Decomposition:
- Shared package/header holds:
  - typ encodings (TYP_B, TYP_H, TYP_W, TYP_D);
  - SPE lookup;
  - state encodings IDLE/RUN;
  - the ROQ_DATA_SIZE=128 constant shared with the ROQ.
- One sub-module, vu_vmu_elem_extract. It is combinational: inputs are entry, slot, typ and signed; output is the 64-bit element. The top level holds the FSM, counters and handshakes.

Test Plan:
- Case 1: cmd vlen=1, typ=3, signed=0; entry 0x00000000_00000002_00000000_00000001.
  - Expect wb 0x1 at idx 0, then 0x2 at idx 1 with wb_last=1.
  - Exactly one pop, coincident with the second fire.
- Case 2: cmd vlen=4, typ=0, signed=1; entry bytes 0x80,0x7F,0xFF,0x01,0x00 at slots 0-4.
  - Expect 0xFFFFFFFFFFFFFF80, 0x7F, 0xFFFFFFFFFFFFFFFF, 0x1, 0x0.
  - Pop occurs on the 5th fire, which is the partial final entry.
- Case 3: cmd vlen=9, typ=2, signed=0, across 3 entries.
  - Pops occur after elements 3, 7 and 9.
  - Indices run 0..9 contiguous; 32-bit values are zero-extended.
- Case 4: hold wb_rdy=0 for 3 cycles mid-entry.
  - wb_data_bits, wb_elem_idx and wb_val stay stable.
  - roq_deq_data_rdy=0 throughout; the stream resumes correctly.
- Case 5: drop roq_deq_data_val for 2 cycles mid-command.
  - wb_val=0 during the gap; no index advance.
- Case 6: assert reset during RUN at elem_idx=3.
  - Next cycle: IDLE, all outputs at reset values.
  - A new command restarts at idx 0 and slot 0.
